ttt_game_ctrl: RTL and testbench
================================

Name: ttt_game_ctrl

Overview:
Turn sequencer and move arbiter for the 3x3 tic-tac-toe cell array. Accepts move requests (row/col) from the input front end and validates them against live cell state. Drives the one-hot cell select and the player bit to the cell array, and alternates X/O. After every committed move it reads the board back and declares a win or a draw.

Parameters:
TIMEOUT_CYCLES, 50_000_000, cycles a player may idle in WAIT_MOVE before forfeiting the turn (used only with MOVE_TIMEOUT_EN); minimum 2.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a new game from any state
move_valid  input  1  move request qualifier, sampled only while move_ready=1
move_row  input  2  requested row, 0..2
move_col  input  2  requested column, 0..2
cell_x  input  9  cell array readback; bit k = cell k holds X, k = row*3+col
cell_o  input  9  cell array readback; bit k = cell k holds O
move_ready  output  1  controller accepting a move this cycle
cell_select  output  9  one-hot cell write strobe to the cell array
player  output  1  current mover: 0 = X, 1 = O
board_clear  output  1  drives the cell array reset
move_reject  output  1  single-cycle pulse: last request illegal
game_over  output  1  high while in OVER
winner  output  2  00 none, 01 X, 10 O, 11 draw; valid when game_over=1
timeout  output  1  single-cycle pulse on turn forfeit; tied 0 when MOVE_TIMEOUT_EN is undefined

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state = IDLE, player = 0, winner = 00
  - move_ready, cell_select, move_reject, game_over and timeout = 0
  - board_clear = 1; it stays high in IDLE so cells are held cleared until a game starts.
- FSM states: IDLE, CLEAR, WAIT_MOVE, COMMIT, CHECK, OVER. All outputs are registered or decoded from registered state only.
- IDLE: start -> CLEAR.
- CLEAR (exactly 1 cycle):
  - board_clear = 1, player forced to 0.
  - Next state WAIT_MOVE.
- WAIT_MOVE: move_ready = 1. With move_valid = 1:
  - Legal move (row <= 2, col <= 2, cell_x[k] = 0 and cell_o[k] = 0): latch k -> COMMIT.
  - Illegal move (row or col = 3, or cell occupied): move_reject = 1 the following cycle; stay in WAIT_MOVE; player unchanged.
- COMMIT (1 cycle):
  - cell_select = one-hot(k); player is held stable.
  - Cells capture at the closing edge.
  - Next state CHECK.
- CHECK (1 cycle): evaluates the now-updated cell_x/cell_o.
  - Any of the 8 lines (3 rows, 3 columns, 2 diagonals) full of the current player's mark -> OVER, winner = 01 (X) or 10 (O).
  - Else, all 9 cells occupied (cell_x | cell_o = 9'h1FF) -> OVER, winner = 11.
  - Else toggle player -> WAIT_MOVE.
- Latency: move accepted in cycle A -> cell_select in A+1 -> CHECK in A+2 -> move_ready (toggled player) or game_over in A+3.
- OVER: game_over = 1, winner held, move_valid ignored. start -> CLEAR.
- move_valid outside WAIT_MOVE is ignored: no reject, no state change.
- start has priority over every state, including COMMIT and CHECK. The in-flight move is abandoned and the next cycle is CLEAR.
- Only the current player's lines are checked in CHECK (the opponent cannot newly win on this move).
- A cell with both cell_x and cell_o set counts as occupied. Line checks use each vector independently.
- cell_select is never multi-hot and is never asserted outside COMMIT.

Optional Feature:
MOVE_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES) clears on every entry to WAIT_MOVE and increments each cycle spent there.
  - At count TIMEOUT_CYCLES-1 with no legal move accepted: pulse timeout for 1 cycle, toggle player, stay in WAIT_MOVE, clear the counter.
  - A legal move in the expiry cycle takes priority (no timeout). An illegal move does not restart the counter.
- Undefined: no counter logic; timeout is constant 0.

Decomposition:
- Package ttt_pkg holds:
  - state_t enum
  - winner encodings (WIN_NONE/WIN_X/WIN_O/WIN_DRAW)
  - PLAYER_X/PLAYER_O
  - the 8 win-line masks as a 9-bit constant array
  - function rc_to_idx(row, col)
- Sub-module ttt_line_check: combinational, input 9-bit mark vector, output 1-bit "has line". One instance for the current player's vector (muxed by player).

Test Plan:
1. Reset then start -> board_clear high for 1 cycle after start, then move_ready=1, player=0, winner=00, cell_select=0.
2. Moves X(0,0), O(1,1), X(0,1), O(2,2), X(0,2) with the cell-array model -> each move gives cell_select 001,010 one-hot pattern (k = 0,4,1,8,2) for 1 cycle. Last move gives game_over=1, winner=01 three cycles after acceptance.
3. Request (1,3), then an occupied cell (0,0) -> move_reject pulse each time, player unchanged, cell_select stays 0.
4. Nine alternating moves with no line (X:0,2,3,7,8 / O:1,4,5,6) -> game_over=1, winner=11 after the ninth.
5. start asserted in the cycle COMMIT is active -> next state CLEAR, board_clear=1, player=0, no CHECK result reported.
6. With MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=8: idle in WAIT_MOVE -> timeout pulse 8 cycles after entry, player 0->1. Legal move in the expiry cycle -> accepted, no timeout pulse.

Source files
------------

// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types, encodings and win-line masks for the tic-tac-toe controller
package ttt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_MOVE,
    S_COMMIT,
    S_CHECK,
    S_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;

  // Cell k = row*3 + col; three rows, three columns, two diagonals.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'b001_010_100, 9'b100_010_001,
    9'b100_100_100, 9'b010_010_010, 9'b001_001_001,
    9'b111_000_000, 9'b000_111_000, 9'b000_000_111
  };

  function automatic logic [3:0] rc_to_idx(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - flags whether a 9-bit mark vector completes any of the 8 win lines
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [8:0] marks_i,
  output logic       has_line_o
);

  always_comb begin
    has_line_o = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((marks_i & WIN_LINES[i]) == WIN_LINES[i]) has_line_o = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe turn sequencer and move arbiter; optional MOVE_TIMEOUT_EN turn forfeit
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       move_valid,
  input  logic [1:0] move_row,
  input  logic [1:0] move_col,
  input  logic [8:0] cell_x,
  input  logic [8:0] cell_o,
  output logic       move_ready,
  output logic [8:0] cell_select,
  output logic       player,
  output logic       board_clear,
  output logic       move_reject,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t     state_q, state_d;
  logic       player_q, player_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] idx_q, idx_d;
  logic       reject_q, reject_d;

  logic [3:0] req_idx;
  logic       req_legal;
  logic       has_line;

  assign req_idx   = rc_to_idx(move_row, move_col);
  assign req_legal = (move_row != 2'd3) && (move_col != 2'd3) &&
                     !cell_x[req_idx] && !cell_o[req_idx];

  // Only the mover can have completed a line on this turn.
  ttt_line_check u_line_check (
    .marks_i    (player_q ? cell_o : cell_x),
    .has_line_o (has_line)
  );

`ifdef MOVE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    winner_d = winner_q;
    idx_d    = idx_q;
    reject_d = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    if (start) begin
      state_d  = S_CLEAR;
      player_d = PLAYER_X;
      winner_d = WIN_NONE;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_CLEAR: begin
          player_d = PLAYER_X;
          state_d  = S_WAIT_MOVE;
`ifdef MOVE_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
        S_WAIT_MOVE: begin
          if (move_valid && req_legal) begin
            idx_d   = req_idx;
            state_d = S_COMMIT;
          end else begin
            reject_d = move_valid;
`ifdef MOVE_TIMEOUT_EN
            if (cnt_q == CNT_LAST) begin
              timeout_d = 1'b1;
              player_d  = ~player_q;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`endif
          end
        end
        S_COMMIT: state_d = S_CHECK;
        S_CHECK: begin
          if (has_line) begin
            state_d  = S_OVER;
            winner_d = (player_q == PLAYER_O) ? WIN_O : WIN_X;
          end else if ((cell_x | cell_o) == 9'h1FF) begin
            state_d  = S_OVER;
            winner_d = WIN_DRAW;
          end else begin
            state_d  = S_WAIT_MOVE;
            player_d = ~player_q;
`ifdef MOVE_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
        S_OVER: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      player_q <= PLAYER_X;
      winner_q <= WIN_NONE;
      idx_q    <= '0;
      reject_q <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      winner_q <= winner_d;
      idx_q    <= idx_d;
      reject_q <= reject_d;
`ifdef MOVE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign move_ready  = (state_q == S_WAIT_MOVE);
  assign cell_select = (state_q == S_COMMIT) ? (9'd1 << idx_q) : 9'd0;
  assign player      = player_q;
  assign board_clear = (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign move_reject = reject_q;
  assign game_over   = (state_q == S_OVER);
  assign winner      = winner_q;
`ifdef MOVE_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - self-checking bench for ttt_game_ctrl with a behavioural game model
module tb_ttt_game_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_row = 2'd0;
  logic [1:0] move_col = 2'd0;
  logic [8:0] cell_x = 9'd0;
  logic [8:0] cell_o = 9'd0;
  logic       move_ready, player, board_clear, move_reject, game_over, timeout;
  logic [8:0] cell_select;
  logic [1:0] winner;

  int total = 0;
  int bad = 0;
  int timeout_seen = 0;

  ttt_game_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .start(start), .move_valid(move_valid),
    .move_row(move_row), .move_col(move_col), .cell_x(cell_x), .cell_o(cell_o),
    .move_ready(move_ready), .cell_select(cell_select), .player(player),
    .board_clear(board_clear), .move_reject(move_reject), .game_over(game_over),
    .winner(winner), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Cell array: cleared while board_clear, captures the mover's mark on the strobed cell.
  always @(posedge clock) begin
    if (board_clear) begin
      cell_x <= 9'd0;
      cell_o <= 9'd0;
    end else begin
      for (int k = 0; k < 9; k++) begin
        if (cell_select[k]) begin
          if (player) cell_o[k] <= 1'b1;
          else        cell_x[k] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) if (timeout) timeout_seen++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic new_game();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clear_board_clear", board_clear, 1);
    chk("clear_ready", move_ready, 0);
    chk("clear_player", player, 0);
    step();
    chk("wait_board_clear", board_clear, 0);
    chk("wait_ready", move_ready, 1);
    chk("wait_player", player, 0);
    chk("wait_winner", winner, 0);
    chk("wait_select", cell_select, 0);
  endtask

  task automatic apply_move(input logic [1:0] r, input logic [1:0] c, input logic rej,
                            input logic ovr, input logic [1:0] win, input logic pl);
    int guard = 0;
    int k;
    k = int'(r) * 3 + int'(c);
    while (!move_ready && guard < 20) begin
      step();
      guard++;
    end
    chk("ready_before_move", move_ready, 1);
    move_valid = 1'b1;
    move_row = r;
    move_col = c;
    step();
    move_valid = 1'b0;
    if (rej) begin
      chk("reject_pulse", move_reject, 1);
      chk("reject_select", cell_select, 0);
      chk("reject_ready", move_ready, 1);
      chk("reject_player", player, 16'(pl));
      step();
      chk("reject_single", move_reject, 0);
    end else begin
      chk("accept_no_reject", move_reject, 0);
      chk("commit_select", cell_select, 16'(9'd1 << k));
      step();
      chk("check_select", cell_select, 0);
      chk("check_ready", move_ready, 0);
      step();
      chk("result_over", game_over, 16'(ovr));
      if (ovr) begin
        chk("result_winner", winner, 16'(win));
        chk("over_ready", move_ready, 0);
      end else begin
        chk("next_ready", move_ready, 1);
        chk("next_player", player, 16'(pl));
      end
    end
  endtask

  task automatic abort_game(input int extra);
    new_game();
    move_valid = 1'b1;
    move_row = 2'd0;
    move_col = 2'd0;
    step();
    move_valid = 1'b0;
    chk("abort_commit_sel", cell_select, 16'h001);
    for (int i = 0; i < extra; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("abort_board_clear", board_clear, 1);
    chk("abort_player", player, 0);
    chk("abort_no_over", game_over, 0);
    chk("abort_select", cell_select, 0);
    step();
    chk("abort_ready", move_ready, 1);
    chk("abort_player2", player, 0);
    apply_move(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  // Reference game model: board[k] 0 empty, 1 X, 2 O.
  function automatic bit line_won(input int b[9], input int p);
    for (int i = 0; i < 3; i++) begin
      if (b[3*i] == p && b[3*i+1] == p && b[3*i+2] == p) return 1;
      if (b[i] == p && b[i+3] == p && b[i+6] == p) return 1;
    end
    if (b[0] == p && b[4] == p && b[8] == p) return 1;
    if (b[2] == p && b[4] == p && b[6] == p) return 1;
    return 0;
  endfunction

  task automatic random_game();
    int b[9];
    int cur = 1;
    int illegal_run = 0;
    bit over = 0;
    int r, c, k, full, ovr, win;
    bit legal;
    for (int i = 0; i < 9; i++) b[i] = 0;
    new_game();
    for (int n = 0; n < 40 && !over; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      if (illegal_run >= 2) begin
        for (int s = 0; s < 9; s++) if (b[s] == 0) begin r = s / 3; c = s % 3; end
      end
      legal = (r < 3) && (c < 3) && (b[(r < 3 ? r : 0) * 3 + (c < 3 ? c : 0)] == 0);
      if (!legal) begin
        illegal_run++;
        apply_move(2'(r), 2'(c), 1'b1, 1'b0, 2'd0, 1'(cur == 2));
      end else begin
        illegal_run = 0;
        k = r * 3 + c;
        b[k] = cur;
        full = 1;
        for (int s = 0; s < 9; s++) if (b[s] == 0) full = 0;
        win = line_won(b, cur) ? cur : (full != 0 ? 3 : 0);
        ovr = (win != 0) ? 1 : 0;
        cur = 3 - cur;
        apply_move(2'(r), 2'(c), 1'b0, 1'(ovr), 2'(win), 1'(cur == 2));
        over = (ovr != 0);
      end
    end
    chk("random_game_finished", 16'(over), 1);
  endtask

  typedef struct {
    logic       ng;
    logic [1:0] r;
    logic [1:0] c;
    logic       rej;
    logic       ovr;
    logic [1:0] win;
    logic       pl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd0, 2'd2, 1'b0, 1'b1, 2'd1, 1'b0},
      '{1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0}, '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1},
      '{1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1},
      '{1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd2, 2'd2, 1'b0, 1'b1, 2'd3, 1'b0},
      '{1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd1, 2'd2, 1'b0, 1'b1, 2'd2, 1'b0},
      '{1'b1, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1}, '{1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0},
      '{1'b0, 2'd2, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0}
    };

    repeat (2) step();
    chk("rst_board_clear", board_clear, 1);
    chk("rst_ready", move_ready, 0);
    chk("rst_select", cell_select, 0);
    chk("rst_player", player, 0);
    chk("rst_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_reject", move_reject, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    step();
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    chk("idle_ignores_move", move_ready, 0);
    chk("idle_no_reject", move_reject, 0);

    foreach (tbl[i]) begin
      if (tbl[i].ng) new_game();
      apply_move(tbl[i].r, tbl[i].c, tbl[i].rej, tbl[i].ovr, tbl[i].win, tbl[i].pl);
    end

    move_valid = 1'b1;
    move_row = 2'd2;
    move_col = 2'd2;
    repeat (2) step();
    move_valid = 1'b0;
    chk("over_held", game_over, 1);
    chk("over_winner_held", winner, 1);
    chk("over_no_reject", move_reject, 0);
    chk("over_no_select", cell_select, 0);

    abort_game(0);
    abort_game(1);

    for (int g = 0; g < 20; g++) random_game();

    new_game();
    reset = 1'b1;
    #2;
    chk("async_rst_ready", move_ready, 0);
    chk("async_rst_board_clear", board_clear, 1);
    reset = 1'b0;
    step();

`ifdef MOVE_TIMEOUT_EN
    new_game();
    for (int i = 0; i < 7; i++) step();
    chk("to_not_yet", timeout, 0);
    step();
    chk("to_pulse", timeout, 1);
    chk("to_player", player, 1);
    chk("to_ready", move_ready, 1);
    for (int i = 0; i < 7; i++) step();
    chk("to_single", timeout, 0);
    move_valid = 1'b1;
    move_row = 2'd1;
    move_col = 2'd1;
    step();
    move_valid = 1'b0;
    chk("to_move_wins", timeout, 0);
    chk("to_move_select", cell_select, 16'h010);
    repeat (2) step();
    chk("to_move_player", player, 0);
`else
    chk("timeout_tied_low", 16'(timeout_seen), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
